store_narrow_buffer: RTL

- Write-side counterpart of the load/immediate extenders: narrows 32-bit store data (sw/sh/sb) into lane-replicated words with byte enables.
- Buffers narrowed stores in a small FIFO and drains them to the data-memory write port over a valid/ready handshake.
- Sits between the MEM-stage store path and the DM write port, so the pipeline does not stall on single memory-busy cycles.

---
 rtl/store_narrow_buffer_pkg.sv | 20 ++
 rtl/store_narrow_buffer_lane_gen.sv | 50 +++++
 rtl/store_narrow_buffer.sv | 112 +++++++++++
 3 files changed

// File: rtl/store_narrow_buffer_pkg.sv
// Shared encodings for the store narrowing buffer: store sizes, byte-enable masks
// and the byte-lane enable helper.
package store_narrow_buffer_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_NONE = 2'b11
  } size_e;

  localparam logic [3:0] BE_ALL = 4'b1111;
  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;

  function automatic logic [3:0] byte_be(input logic [1:0] lane);
    byte_be = 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/store_narrow_buffer_lane_gen.sv
// store_lane_gen: combinational narrowing of a raw store into lane-replicated data and
// byte enables. STORE_MISALIGN_TRAP_EN enables misaligned-store detection.
module store_lane_gen
  import store_narrow_buffer_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  // Size decode into byte enables, replicated data and the misalignment flag
  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = 32'h0000_0000;
    o_misaligned = 1'b0;
    case (size_e'(i_size))
      SZ_WORD: begin
        o_be    = BE_ALL;
        o_wdata = i_data;
`ifdef STORE_MISALIGN_TRAP_EN
        o_misaligned = (i_addr_lo != 2'b00);
`else
        o_misaligned = 1'b0;
`endif
      end
      SZ_HALF: begin
        o_be    = i_addr_lo[1] ? BE_HI : BE_LO;
        o_wdata = {2{i_data[15:0]}};
`ifdef STORE_MISALIGN_TRAP_EN
        o_misaligned = i_addr_lo[0];
`else
        o_misaligned = 1'b0;
`endif
      end
      SZ_BYTE: begin
        o_be    = byte_be(i_addr_lo);
        o_wdata = {4{i_data[7:0]}};
      end
      default: begin
        o_be         = 4'b0000;
        o_wdata      = 32'h0000_0000;
        o_misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows stores and queues them in a DEPTH-entry FIFO drained over
// a valid/ready port. STORE_MISALIGN_TRAP_EN drops misaligned stores and pulses misalign.
module store_narrow_buffer
  import store_narrow_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [31:0]                in_data,
  input  logic [1:0]                 in_size,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [AW-1:0]              mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       misalign
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_addr  [DEPTH];
  logic [31:0]   r_wdata [DEPTH];
  logic [3:0]    r_be    [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_mis;
  logic          w_nonempty;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  store_lane_gen u_lane_gen (
    .i_addr_lo    (in_addr[1:0]),
    .i_size       (in_size),
    .i_data       (in_data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_mis)
  );

  // Ready looks only at registered occupancy, so a full buffer refuses even when popping
  assign in_ready   = (r_count < CW'(DEPTH));
  assign w_nonempty = (r_count != {CW{1'b0}});
  assign w_accept   = in_valid && in_ready;
  assign w_push     = w_accept && (in_size != SZ_NONE) && !w_mis;
  assign w_pop      = w_nonempty && mem_ready;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i]  <= {AW{1'b0}};
        r_wdata[i] <= 32'h0000_0000;
        r_be[i]    <= 4'b0000;
      end
    end else begin
      if (w_push) begin
        r_addr[r_wptr]  <= {in_addr[AW-1:2], 2'b00};
        r_wdata[r_wptr] <= w_wdata;
        r_be[r_wptr]    <= w_be;
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Popped slots keep stale contents, so the head is masked whenever the buffer is empty
  assign mem_valid = w_nonempty;
  assign mem_addr  = w_nonempty ? r_addr[r_rptr]  : {AW{1'b0}};
  assign mem_wdata = w_nonempty ? r_wdata[r_rptr] : 32'h0000_0000;
  assign mem_be    = w_nonempty ? r_be[r_rptr]    : 4'b0000;
  assign count     = r_count;

`ifdef STORE_MISALIGN_TRAP_EN
  logic r_misalign;

  // One-cycle pulse after a misaligned store is accepted and dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept && w_mis;
    end
  end

  assign misalign = r_misalign;
`else
  assign misalign = 1'b0;
`endif

endmodule
